// File: rtl/matmul_nxn_fp32.sv
// N x N single-precision matrix multiplier (C = A*B or C += A*B) built around one
// time-shared multiplier and one adder, two cycles per multiply-accumulate step.
module matmul_nxn_fp32 #(
    parameter int N = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              acc,
    input  logic [N*N*32-1:0] mat1,
    input  logic [N*N*32-1:0] mat2,
    output logic [N*N*32-1:0] result,
    output logic              busy,
    output logic              done
);

    localparam int W = N * N * 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] LAST = 2'(N - 1);

    // Word 0 of a packed matrix is element [0][0] at the MSB end.
    function automatic logic [31:0] get_word(input logic [W-1:0] v, input logic [3:0] idx);
        return v[(N * N - 1 - int'(idx)) * 32 +: 32];
    endfunction

    function automatic logic [W-1:0] put_word(input logic [W-1:0] v, input logic [3:0] idx,
                                              input logic [31:0] w);
        logic [W-1:0] r;
        r = v;
        r[(N * N - 1 - int'(idx)) * 32 +: 32] = w;
        return r;
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [22:0] mant;
        logic [9:0]  e;
        logic        sign;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC0_0000;
        if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return 32'h0000_0000;
        sign = a[31] ^ b[31];
        p    = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
        mant = p[47] ? 23'(p >> 24) : 23'(p >> 23);
        e    = {2'b00, a[30:23]} + {2'b00, b[30:23]} + {9'h0, p[47]} - 10'd127;
        if (e[9] || e == 10'd0) return 32'h0000_0000;
        if (e >= 10'd255) return {sign, 8'hFF, 23'h0};
        return {sign, e[7:0], mant};
    endfunction

    // Zero operands pass the other operand through before the special-exponent rule.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x;
        logic [31:0] y;
        logic [23:0] mx;
        logic [23:0] my;
        logic [23:0] diff;
        logic [24:0] s;
        logic [22:0] mant;
        logic [9:0]  e;
        logic [4:0]  lz;
        logic        sign;
        if (a[30:23] == 8'h00) return (b[30:23] == 8'h00) ? 32'h0000_0000 : b;
        if (b[30:23] == 8'h00) return a;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC0_0000;
        if (a[30:23] >= b[30:23]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        mx = {1'b1, x[22:0]};
        my = {1'b1, y[22:0]} >> (x[30:23] - y[30:23]);
        e  = {2'b00, x[30:23]};
        if (x[31] == y[31]) begin
            sign = x[31];
            s    = {1'b0, mx} + {1'b0, my};
            if (s[24]) begin
                mant = 23'(s >> 1);
                e    = e + 10'd1;
            end else begin
                mant = 23'(s);
            end
        end else begin
            if (my > mx) begin
                diff = my - mx;
                sign = y[31];
            end else begin
                diff = mx - my;
                sign = x[31];
            end
            if (diff == 24'h0) return 32'h0000_0000;
            lz = 5'd0;
            for (int n = 0; n < 24; n++) begin
                if (diff[n]) lz = 5'(23 - n);
            end
            mant = 23'(diff << lz);
            e    = e - {5'b0, lz};
        end
        if (e[9] || e == 10'd0) return 32'h0000_0000;
        if (e >= 10'd255) return {sign, 8'hFF, 23'h0};
        return {sign, e[7:0], mant};
    endfunction

    logic [1:0]   state_q, state_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic         acc_q, acc_d;
    logic [1:0]   i_q, i_d;
    logic [1:0]   j_q, j_d;
    logic [1:0]   k_q, k_d;
    logic         ph_q, ph_d;
    logic [31:0]  prod_q, prod_d;
    logic [31:0]  sum_q, sum_d;
    logic [W-1:0] cbuf_q, cbuf_d;
    logic [W-1:0] result_q, result_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [3:0]   idx_a;
    logic [3:0]   idx_b;
    logic [3:0]   idx_c;
    logic [31:0]  addend;
    logic [31:0]  new_sum;

    assign idx_a = 4'(int'(i_q) * N + int'(k_q));
    assign idx_b = 4'(int'(k_q) * N + int'(j_q));
    assign idx_c = 4'(int'(i_q) * N + int'(j_q));

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        ph_d     = ph_q;
        prod_d   = prod_q;
        sum_d    = sum_q;
        cbuf_d   = cbuf_q;
        result_d = result_q;
        busy_d   = (state_q == S_CALC);
        done_d   = 1'b0;
        addend   = 32'h0;
        new_sum  = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = mat1;
                    b_d     = mat2;
                    acc_d   = acc;
                    i_d     = 2'd0;
                    j_d     = 2'd0;
                    k_d     = 2'd0;
                    ph_d    = 1'b0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (!ph_q) begin
                    prod_d = fp_mul(get_word(a_q, idx_a), get_word(b_q, idx_b));
                    ph_d   = 1'b1;
                end else begin
                    if (k_q != 2'd0) addend = sum_q;
                    else if (acc_q)  addend = get_word(result_q, idx_c);
                    new_sum = fp_add(addend, prod_q);
                    sum_d   = new_sum;
                    ph_d    = 1'b0;
                    if (k_q == LAST) begin
                        cbuf_d = put_word(cbuf_q, idx_c, new_sum);
                        k_d    = 2'd0;
                        if (j_q == LAST) begin
                            j_d = 2'd0;
                            if (i_q == LAST) begin
                                i_d     = 2'd0;
                                state_d = S_DONE;
                            end else begin
                                i_d = i_q + 2'd1;
                            end
                        end else begin
                            j_d = j_q + 2'd1;
                        end
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end
            S_DONE: begin
                result_d = cbuf_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= 1'b0;
            i_q      <= 2'd0;
            j_q      <= 2'd0;
            k_q      <= 2'd0;
            ph_q     <= 1'b0;
            prod_q   <= 32'h0;
            sum_q    <= 32'h0;
            cbuf_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            ph_q     <= ph_d;
            prod_q   <= prod_d;
            sum_q    <= sum_d;
            cbuf_q   <= cbuf_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_matmul_nxn_fp32.sv
// Scoreboard bench for matmul_nxn_fp32: a 2x2 instance for the main and corner tests
// and a 3x3 instance for the identity test.
module tb_matmul_nxn_fp32;

    typedef struct {
        logic [511:0] res;
        int           t0;
    } exp_t;

    localparam logic [127:0] MA  = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    localparam logic [127:0] MB  = {32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    localparam logic [127:0] C1  = {32'h41980000, 32'h41B00000, 32'h422C0000, 32'h42480000};
    localparam logic [127:0] C2  = {32'h42180000, 32'h42300000, 32'h42AC0000, 32'h42C80000};
    localparam logic [127:0] S1A = {32'h7F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    localparam logic [127:0] S1C = {32'h7FC00000, 32'h7FC00000, 32'h422C0000, 32'h42480000};
    localparam logic [127:0] S2A = {32'h71800000, 32'h0, 32'h0, 32'h0};
    localparam logic [127:0] S2C = {32'h7F800000, 32'h0, 32'h0, 32'h0};
    localparam logic [287:0] I3  = {32'h3F800000, 32'h0, 32'h0,
                                    32'h0, 32'h3F800000, 32'h0,
                                    32'h0, 32'h0, 32'h3F800000};
    localparam logic [287:0] B3  = {32'h3F800000, 32'h40000000, 32'h40400000,
                                    32'h40800000, 32'h40A00000, 32'h40C00000,
                                    32'h40E00000, 32'h41000000, 32'h41100000};

    logic         clk = 1'b0;
    logic         rst2 = 1'b1, start2 = 1'b0, acc2 = 1'b0;
    logic [127:0] mat1_2 = '0, mat2_2 = '0;
    logic [127:0] result2;
    logic         busy2, done2;
    logic         rst3 = 1'b1, start3 = 1'b0, acc3 = 1'b0;
    logic [287:0] mat1_3 = '0, mat2_3 = '0;
    logic [287:0] result3;
    logic         busy3, done3;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q2[$];
    exp_t q3[$];
    logic prev_done2 = 1'b0;
    logic prev_done3 = 1'b0;

    matmul_nxn_fp32 #(.N(2)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .acc(acc2), .mat1(mat1_2), .mat2(mat2_2),
        .result(result2), .busy(busy2), .done(done2)
    );

    matmul_nxn_fp32 #(.N(3)) dut3 (
        .clk(clk), .rst(rst3), .start(start3), .acc(acc3), .mat1(mat1_3), .mat2(mat2_3),
        .result(result3), .busy(busy3), .done(done3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_vec(input string name, input logic [511:0] got, input logic [511:0] exp,
                             input int nw);
        for (int w = 0; w < nw; w++) begin
            check($sformatf("%s_word%0d", name, w),
                  got[(nw - 1 - w) * 32 +: 32], exp[(nw - 1 - w) * 32 +: 32]);
        end
    endtask

    // Monitors: pop the oldest expectation whenever a done pulse appears.
    always @(negedge clk) begin
        exp_t e;
        if (done2) begin
            check("d2_done_width", {31'h0, prev_done2}, 32'h0);
            check("d2_busy_in_done", {31'h0, busy2}, 32'h0);
            if (q2.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL d2_unexpected_done: done seen with no accepted start at cycle %0d", cyc);
            end else begin
                e = q2.pop_front();
                check("d2_latency", 32'(cyc - e.t0), 32'd17);
                check_vec("d2_result", {384'h0, result2}, e.res, 4);
            end
        end
        prev_done2 = done2;
    end

    always @(negedge clk) begin
        exp_t e;
        if (done3) begin
            check("d3_done_width", {31'h0, prev_done3}, 32'h0);
            if (q3.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL d3_unexpected_done: done seen with no accepted start at cycle %0d", cyc);
            end else begin
                e = q3.pop_front();
                check("d3_latency", 32'(cyc - e.t0), 32'd55);
                check_vec("d3_result", {224'h0, result3}, e.res, 9);
            end
        end
        prev_done3 = done3;
    end

    task automatic wait_done2();
        int n = 0;
        while (!done2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done2) begin
            n_checks++;
            n_fail++;
            $display("FAIL d2_timeout: no done within 200 cycles (cycle %0d)", cyc);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic issue2(input logic [127:0] a, input logic [127:0] b, input logic ac,
                          input logic [127:0] exp, input bit noise, input logic [31:0] prev0);
        exp_t e;
        mat1_2 = a;
        mat2_2 = b;
        acc2   = ac;
        start2 = 1'b1;
        e.res  = {384'h0, exp};
        e.t0   = cyc + 1;
        q2.push_back(e);
        @(negedge clk);
        start2 = 1'b0;
        @(negedge clk);
        check("d2_busy_calc", {31'h0, busy2}, 32'h1);
        if (noise) begin
            repeat (4) @(negedge clk);
            check("d2_result_held", result2[127:96], prev0);
            mat1_2 = S2A;
            acc2   = 1'b1;
            start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
            mat1_2 = a;
            acc2   = ac;
        end
        wait_done2();
    endtask

    initial begin
        exp_t e;
        int   n;
        repeat (2) @(negedge clk);
        check_vec("d2_reset_result", {384'h0, result2}, 512'h0, 4);
        check("d2_reset_busy", {31'h0, busy2}, 32'h0);
        check("d2_reset_done", {31'h0, done2}, 32'h0);
        rst2 = 1'b0;
        rst3 = 1'b0;
        @(negedge clk);

        issue2(MA, MB, 1'b0, C1, 1'b0, 32'h0);
        issue2(MA, MB, 1'b1, C2, 1'b0, 32'h0);
        issue2(MA, MB, 1'b0, C1, 1'b1, C2[127:96]);
        issue2(S1A, MB, 1'b0, S1C, 1'b0, 32'h0);
        issue2(S2A, S2A, 1'b0, S2C, 1'b0, 32'h0);
        @(negedge clk);

        // Abort an operation with reset; no done may follow.
        mat1_2 = MA;
        mat2_2 = MB;
        acc2   = 1'b0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (5) @(negedge clk);
        rst2 = 1'b1;
        repeat (2) @(negedge clk);
        rst2 = 1'b0;
        check_vec("d2_midrst_result", {384'h0, result2}, 512'h0, 4);
        check("d2_midrst_busy", {31'h0, busy2}, 32'h0);
        check("d2_midrst_done", {31'h0, done2}, 32'h0);
        repeat (30) @(negedge clk);

        // Reset and start on the same edge: reset wins.
        rst2   = 1'b1;
        start2 = 1'b1;
        @(negedge clk);
        rst2   = 1'b0;
        start2 = 1'b0;
        repeat (2) @(negedge clk);
        check("d2_rst_beats_start", {31'h0, busy2}, 32'h0);

        issue2(MA, MB, 1'b1, C1, 1'b0, 32'h0);
        @(negedge clk);

        mat1_3 = I3;
        mat2_3 = B3;
        acc3   = 1'b0;
        start3 = 1'b1;
        e.res  = {224'h0, B3};
        e.t0   = cyc + 1;
        q3.push_back(e);
        @(negedge clk);
        start3 = 1'b0;
        n = 0;
        while (!done3 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!done3) begin
            n_checks++;
            n_fail++;
            $display("FAIL d3_timeout: no done within 300 cycles (cycle %0d)", cyc);
        end

        repeat (5) @(negedge clk);
        check("q2_drained", q2.size(), 32'h0);
        check("q3_drained", q3.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
